// File: rtl/seq_arith_pkg.sv
// rtl/seq_arith_pkg.sv - shared op codes, FSM states and flag levels for seq_arith_ctrl
package seq_arith_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_A,
        ST_WAIT_A,
        ST_FETCH_B,
        ST_WAIT_B,
        ST_EXEC,
        ST_ITER,
        ST_OUTPUT,
        ST_NEXT
    } state_t;

    // res_flag: add carry, sub borrow, mul high-half nonzero, div by zero
    localparam logic FLAG_CLR = 1'b0;
    localparam logic FLAG_SET = 1'b1;

    function automatic logic is_iter_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module seq_muldiv #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              fin,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              dz
);
    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] hi_r, lo_r, b_r;
    logic [CW-1:0]     cnt;
    logic              div_r;
    logic [DATA_W:0]   mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [DATA_W-1:0] hi_nx, lo_nx;

    assign dz = is_div && (b == '0);

    always_comb begin
        mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
        div_shift = {hi_r, lo_r[DATA_W-1]};
        div_diff  = div_shift - {1'b0, b_r};
        div_ge    = (div_shift >= {1'b0, b_r});
        if (div_r) begin
            hi_nx = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
            lo_nx = {lo_r[DATA_W-2:0], div_ge};
        end else begin
            hi_nx = mul_sum[DATA_W:1];
            lo_nx = {mul_sum[0], lo_r[DATA_W-1:1]};
        end
    end

    // lo/hi carry the post-step value, so they hold the final result in the fin cycle
    assign fin = busy && (cnt == CW'(1));
    assign lo  = lo_nx;
    assign hi  = hi_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r  <= '0;
            lo_r  <= '0;
            b_r   <= '0;
            cnt   <= '0;
            div_r <= 1'b0;
            busy  <= 1'b0;
        end else if (go && !dz && !busy) begin
            hi_r  <= '0;
            lo_r  <= a;
            b_r   <= b;
            div_r <= is_div;
            cnt   <= CW'(DATA_W);
            busy  <= 1'b1;
        end else if (busy) begin
            hi_r <= hi_nx;
            lo_r <= lo_nx;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_arith_ctrl.sv
// rtl/seq_arith_ctrl.sv - fetches operand pairs from ROM and applies add/sub/mul/div in turn
module seq_arith_ctrl
    import seq_arith_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int NUM_PAIRS = 4,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_op,
    output logic [DATA_W-1:0] res_lo,
    output logic [DATA_W-1:0] res_hi,
    output logic              res_flag,
    output logic              busy,
    output logic              done
);
    localparam int KW = $clog2(NUM_PAIRS + 1);

    state_t            state;
    logic [KW-1:0]     k;
    logic [1:0]        op;
    logic [ADDR_W-1:0] ptr;
    logic [2:0]        wcnt;
    logic [DATA_W-1:0] a_r, b_r;
    logic [DATA_W:0]   sum, diff;

    logic              md_go, md_is_div, md_busy, md_fin, md_dz;
    logic [DATA_W-1:0] md_lo, md_hi;

    assign sum       = {1'b0, a_r} + {1'b0, b_r};
    assign diff      = {1'b0, a_r} - {1'b0, b_r};
    assign md_go     = (state == ST_EXEC) && is_iter_op(op) && !md_busy;
    assign md_is_div = (op == OP_DIV);

    seq_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .go     (md_go),
        .is_div (md_is_div),
        .a      (a_r),
        .b      (b_r),
        .busy   (md_busy),
        .fin    (md_fin),
        .lo     (md_lo),
        .hi     (md_hi),
        .dz     (md_dz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            k         <= '0;
            op        <= OP_ADD;
            ptr       <= ADDR_W'(BASE_ADDR);
            wcnt      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
            res_valid <= 1'b0;
            res_op    <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            res_flag  <= FLAG_CLR;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rom_rd <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH_A;
                        busy     <= 1'b1;
                        rom_rd   <= 1'b1;
                        rom_addr <= ptr;
                    end
                end
                ST_FETCH_A: begin
                    state <= ST_WAIT_A;
                    wcnt  <= 3'(RD_LAT - 1);
                end
                ST_WAIT_A: begin
                    if (wcnt == 3'd0) begin
                        a_r      <= rom_data;
                        state    <= ST_FETCH_B;
                        rom_rd   <= 1'b1;
                        rom_addr <= ptr + ADDR_W'(1);
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                ST_FETCH_B: begin
                    state <= ST_WAIT_B;
                    wcnt  <= 3'(RD_LAT - 1);
                end
                ST_WAIT_B: begin
                    if (wcnt == 3'd0) begin
                        b_r   <= rom_data;
                        state <= ST_EXEC;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                ST_EXEC: begin
                    res_op <= op;
                    case (op)
                        OP_ADD: begin
                            res_lo    <= sum[DATA_W-1:0];
                            res_hi    <= '0;
                            res_flag  <= sum[DATA_W];
                            res_valid <= 1'b1;
                            state     <= ST_OUTPUT;
                        end
                        OP_SUB: begin
                            res_lo    <= diff[DATA_W-1:0];
                            res_hi    <= '0;
                            res_flag  <= (a_r < b_r) ? FLAG_SET : FLAG_CLR;
                            res_valid <= 1'b1;
                            state     <= ST_OUTPUT;
                        end
                        default: begin
                            // divide-by-zero bypasses the iterative unit entirely
                            if (md_dz) begin
                                res_lo    <= '1;
                                res_hi    <= a_r;
                                res_flag  <= FLAG_SET;
                                res_valid <= 1'b1;
                                state     <= ST_OUTPUT;
                            end else begin
                                state <= ST_ITER;
                            end
                        end
                    endcase
                end
                ST_ITER: begin
                    if (md_fin) begin
                        res_lo    <= md_lo;
                        res_hi    <= md_hi;
                        res_flag  <= (op == OP_MUL) ? (md_hi != '0) : FLAG_CLR;
                        res_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (k == KW'(NUM_PAIRS - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        k     <= '0;
                        op    <= OP_ADD;
                        ptr   <= ADDR_W'(BASE_ADDR);
                        state <= ST_IDLE;
                    end else begin
                        k        <= k + KW'(1);
                        op       <= op + 2'd1;
                        ptr      <= ptr + ADDR_W'(2);
                        rom_rd   <= 1'b1;
                        rom_addr <= ptr + ADDR_W'(2);
                        state    <= ST_FETCH_A;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_arith_ctrl.md
Name: seq_arith_ctrl

Overview:
- Parametrised successor to the four-operation arithmetic controller.
- Fetches NUM_PAIRS operand pairs (A, B) from a ROM with configurable read latency and applies a cyclic operation sequence to each pair: add, sub, mul, div.
- Multiply is a shift-add iterative unit and divide is a restoring iterative unit, both DATA_W cycles.
- Each result is presented on a valid/ready output handshake with a status flag, then the block moves to the next pair.
- Sits between the operand ROM and the result register/display path.

Parameters:
- DATA_W, 16, operand width (unsigned), range 4..32.
- ADDR_W, 9, ROM address width.
- NUM_PAIRS, 4, operand pairs processed per start.
- BASE_ADDR, 0, ROM address of the first A operand.
- RD_LAT, 1, ROM read latency in cycles, range 1..4.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  begin a run; sampled only in IDLE.
- rom_rd  out  1  one-cycle ROM read strobe.
- rom_addr  out  ADDR_W  ROM address, valid while rom_rd=1.
- rom_data  in  DATA_W  ROM word, valid RD_LAT cycles after the rom_rd cycle.
- res_valid  out  1  result available; held until accepted.
- res_ready  in  1  consumer accepts when res_valid & res_ready.
- res_op  out  2  0=add, 1=sub, 2=mul, 3=div.
- res_lo  out  DATA_W  sum / difference / product low / quotient.
- res_hi  out  DATA_W  0 / 0 / product high / remainder.
- res_flag  out  1  add carry-out, sub borrow (A<B), mul (res_hi!=0), div divide-by-zero.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last pair's result is accepted.

Behaviour:
- Reset: state IDLE; rom_rd, res_valid, busy, done, res_flag all 0; rom_addr, res_op, res_lo, res_hi 0; pair index 0.
- Reset mid-run: in-flight data is discarded. No partial result is presented.
- States: IDLE, FETCH_A, WAIT_A, FETCH_B, WAIT_B, EXEC, ITER, OUTPUT, NEXT.
- IDLE: when start=1, go to FETCH_A and set busy=1 from the next cycle. start while busy is ignored.
- FETCH_A: rom_rd=1, rom_addr=BASE_ADDR+2k. Next state WAIT_A.
- WAIT_A: lasts RD_LAT cycles. Capture rom_data on the last cycle.
- FETCH_B / WAIT_B: same as FETCH_A / WAIT_A with rom_addr=BASE_ADDR+2k+1.
- Address arithmetic is modulo 2^ADDR_W (wrap permitted).
- Operation for pair k is k mod 4.
- EXEC, add/sub: result computed in one cycle, then OUTPUT.
  - add: res_lo = (A+B) mod 2^DATA_W, flag = carry.
  - sub: res_lo = (A-B) mod 2^DATA_W, flag = borrow.
- EXEC, mul/div: initialise the iteration counter to DATA_W, then ITER for exactly DATA_W cycles, one bit per cycle.
- mul: full 2*DATA_W product. B=0 still takes DATA_W cycles, result 0.
- div: restoring, quotient and remainder.
  - B=0: skip ITER; res_lo = all ones, res_hi = A, flag=1.
  - A<B: normal iteration, quotient 0, remainder A.
- OUTPUT: res_valid=1; outputs stay stable until res_ready. On the accept cycle go to NEXT.
- NEXT: k++. If k==NUM_PAIRS: done=1 for one cycle, busy=0, k=0, go to IDLE. Otherwise go to FETCH_A.
- Latency from the start cycle t to the first res_valid: t+4+2*RD_LAT for add/sub, plus DATA_W for mul/div, 0 extra for div-by-zero.
- rom_data outside the capture cycle is ignored.
- res_ready while res_valid=0 has no effect.

Decomposition:
- Shared package seq_arith_pkg holds:
  - op-code constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - the state enumeration;
  - the flag-meaning constants.
- One sub-module, seq_muldiv: iterative shift-add multiplier / restoring divider.
  - Parameter DATA_W.
  - Ports: go, is_div, a, b, busy, fin, lo, hi, dz.
  - Reused by the controller's ITER state.

Test Plan:
- DATA_W=16, RD_LAT=1, ROM[0..1]=(0xFFFF,0x0001), start at t → rom_rd at t+1 (addr 0) and t+3 (addr 1); res_valid at t+6 with op=0, lo=0x0000, flag=1.
- Pair 1 ROM=(0x0003,0x0005) → op=1, lo=0xFFFE, hi=0, flag=1. Hold res_ready=0 for 5 cycles: outputs stable, no new rom_rd.
- Pair 2 ROM=(0x0100,0x0100) → op=2, lo=0x0000, hi=0x0001, flag=1. res_valid exactly 16 cycles later than for an add.
- Pair 3 ROM=(0x0064,0x0000) → op=3, lo=0xFFFF, hi=0x0064, flag=1, no ITER cycles. Then done pulses once and busy drops.
- Pair 3 ROM=(0x0007,0x0009) → quotient 0, remainder 7, flag=0. Also (1000,7) → quotient 142, remainder 6.
- Assert reset during ITER of mul → next cycle IDLE with all outputs zero. start pulsed while busy (before reset) is ignored. RD_LAT=3 variant: capture happens 3 cycles after rom_rd.
